// File: rtl/float754_to_int.sv
// IEEE-754 single-precision to signed integer converter, one mantissa bit shift per cycle.
// A rising edge on inputCS starts a conversion; outputCS pulses for one cycle when IntOutput is updated.
module float754_to_int #(
  parameter int OUT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          Data754,
  input  logic                 inputCS,
  output logic [OUT_WIDTH-1:0] IntOutput,
  output logic                 outputCS,
  output logic                 Busy,
  output logic                 Overflow,
  output logic                 Invalid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [2:0] C_ZERO = 3'd0;
  localparam logic [2:0] C_NAN  = 3'd1;
  localparam logic [2:0] C_SAT  = 3'd2;
  localparam logic [2:0] C_MIN  = 3'd3;
  localparam logic [2:0] C_NORM = 3'd4;

  // Biased exponent thresholds: 127 is e=0, 150 is e=23, EXP_LIM is e=OUT_WIDTH-1.
  localparam logic [8:0] EXP_BIAS  = 9'd127;
  localparam logic [8:0] EXP_UNITY = 9'd150;
  localparam logic [8:0] EXP_LIM   = 9'(9'd126 + 9'(OUT_WIDTH));

  localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [1:0]           state_q, state_d;
  logic                 prev_q, prev_d;
  logic                 arm_q, arm_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          work_q, work_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 left_q, left_d;
  logic [2:0]           cls_q, cls_d;
  logic [OUT_WIDTH-1:0] int_q, int_d;
  logic                 ocs_q, ocs_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic                 inv_q, inv_d;

  logic                 start_s;
  logic                 sign_s;
  logic [8:0]           exp_s;
  logic [22:0]          frac_s;
  logic [2:0]           cls_s;
  logic [4:0]           n_s;
  logic                 left_s;
  logic [OUT_WIDTH-1:0] mag_s;
  logic [OUT_WIDTH-1:0] neg_s;

  // arm_q blocks a start until inputCS has been seen low after reset.
  assign start_s = inputCS & ~prev_q & arm_q;
  assign sign_s  = data_q[31];
  assign exp_s   = {1'b0, data_q[30:23]};
  assign frac_s  = data_q[22:0];
  assign mag_s   = work_q[OUT_WIDTH-1:0];
  assign neg_s   = (~mag_s) + OUT_WIDTH'(1'b1);

  // Classify the captured operand and derive shift count and direction.
  always_comb begin
    cls_s  = C_NORM;
    n_s    = 5'd0;
    left_s = 1'b0;
    if (exp_s == 9'd255) begin
      if (frac_s != 23'd0) begin
        cls_s = C_NAN;
      end else begin
        cls_s = C_SAT;
      end
    end else if (exp_s < EXP_BIAS) begin
      cls_s = C_ZERO;
    end else if (exp_s >= EXP_LIM) begin
      if (sign_s && (exp_s == EXP_LIM) && (frac_s == 23'd0)) begin
        cls_s = C_MIN;
      end else begin
        cls_s = C_SAT;
      end
    end else begin
      cls_s = C_NORM;
      if (exp_s < EXP_UNITY) begin
        n_s    = 5'(EXP_UNITY - exp_s);
        left_s = 1'b0;
      end else begin
        n_s    = 5'(exp_s - EXP_UNITY);
        left_s = 1'b1;
      end
    end
  end

  // Conversion FSM and datapath next-state logic.
  always_comb begin
    state_d = state_q;
    prev_d  = inputCS;
    arm_d   = arm_q | ~inputCS;
    data_d  = data_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    cls_d   = cls_q;
    int_d   = int_q;
    ocs_d   = 1'b0;
    ovf_d   = ovf_q;
    inv_d   = inv_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          data_d  = Data754;
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        cls_d  = cls_s;
        work_d = {8'd0, 1'b1, frac_s};
        cnt_d  = n_s;
        left_d = left_s;
        if (n_s == 5'd0) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (left_q) begin
          work_d = {work_q[30:0], 1'b0};
        end else begin
          work_d = {1'b0, work_q[31:1]};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_FINISH: begin
        ocs_d   = 1'b1;
        ovf_d   = 1'b0;
        inv_d   = 1'b0;
        state_d = S_IDLE;
        case (cls_q)
          C_NORM: begin
            if (sign_s) begin
              int_d = neg_s;
            end else begin
              int_d = mag_s;
            end
          end
          C_NAN: begin
            int_d = {OUT_WIDTH{1'b0}};
            inv_d = 1'b1;
          end
          C_SAT: begin
            ovf_d = 1'b1;
            if (sign_s) begin
              int_d = MIN_NEG;
            end else begin
              int_d = MAX_POS;
            end
          end
          C_MIN: begin
            int_d = MIN_NEG;
          end
          default: begin
            int_d = {OUT_WIDTH{1'b0}};
          end
        endcase
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      prev_q  <= 1'b0;
      arm_q   <= 1'b0;
      data_q  <= 32'd0;
      work_q  <= 32'd0;
      cnt_q   <= 5'd0;
      left_q  <= 1'b0;
      cls_q   <= C_ZERO;
      int_q   <= {OUT_WIDTH{1'b0}};
      ocs_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      arm_q   <= arm_d;
      data_q  <= data_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      cls_q   <= cls_d;
      int_q   <= int_d;
      ocs_q   <= ocs_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      inv_q   <= inv_d;
    end
  end

  assign IntOutput = int_q;
  assign outputCS  = ocs_q;
  assign Busy      = busy_q;
  assign Overflow  = ovf_q;
  assign Invalid   = inv_q;

endmodule

// File: tb/tb_float754_to_int.sv
// Directed bench for float754_to_int: a 16-bit instance for most vectors and a 32-bit
// instance for left-shift and full-width boundaries.
module tb_float754_to_int;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Data754;
  logic        inputCS;
  logic        cs32;

  logic [15:0] int16;
  logic        ocs16, busy16, ovf16, inv16;
  logic [31:0] int32;
  logic        ocs32, busy32, ovf32, inv32;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  float754_to_int #(.OUT_WIDTH(16)) dut16 (
    .CLK(CLK), .RST(RST), .Data754(Data754), .inputCS(inputCS),
    .IntOutput(int16), .outputCS(ocs16), .Busy(busy16), .Overflow(ovf16), .Invalid(inv16)
  );

  float754_to_int #(.OUT_WIDTH(32)) dut32 (
    .CLK(CLK), .RST(RST), .Data754(Data754), .inputCS(cs32),
    .IntOutput(int32), .outputCS(ocs32), .Busy(busy32), .Overflow(ovf32), .Invalid(inv32)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        wide;
    logic [31:0] r;
    logic        o;
    logic        i;
    logic [7:0]  lat;
  } vec_t;

  // operand, 32-bit instance?, result (16-bit results zero-extended), Overflow, Invalid, latency
  localparam vec_t VECS [0:20] = '{
    '{32'h3F800000, 1'b0, 32'h00000001, 1'b0, 1'b0, 8'd25},  // 1.0
    '{32'hC0200000, 1'b0, 32'h0000FFFE, 1'b0, 1'b0, 8'd24},  // -2.5
    '{32'h3F000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 8'd2},   // 0.5
    '{32'h4640E400, 1'b0, 32'h00003039, 1'b0, 1'b0, 8'd12},  // 12345.0
    '{32'hC640E400, 1'b0, 32'h0000CFC7, 1'b0, 1'b0, 8'd12},  // -12345.0
    '{32'h3FE00000, 1'b0, 32'h00000001, 1'b0, 1'b0, 8'd25},  // 1.75
    '{32'h46FFFE00, 1'b0, 32'h00007FFF, 1'b0, 1'b0, 8'd11},  // 32767.0
    '{32'h47000000, 1'b0, 32'h00007FFF, 1'b1, 1'b0, 8'd2},   // 32768.0
    '{32'hC7000000, 1'b0, 32'h00008000, 1'b0, 1'b0, 8'd2},   // -32768.0
    '{32'hC7000100, 1'b0, 32'h00008000, 1'b1, 1'b0, 8'd2},   // -32769.0
    '{32'hFF800000, 1'b0, 32'h00008000, 1'b1, 1'b0, 8'd2},   // -inf
    '{32'h7F800000, 1'b0, 32'h00007FFF, 1'b1, 1'b0, 8'd2},   // +inf
    '{32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 8'd2},   // -0.0
    '{32'h80000001, 1'b0, 32'h00000000, 1'b0, 1'b0, 8'd2},   // denormal
    '{32'h7FC00000, 1'b0, 32'h00000000, 1'b0, 1'b1, 8'd2},   // NaN
    '{32'h40400000, 1'b0, 32'h00000003, 1'b0, 1'b0, 8'd24},  // 3.0
    '{32'h4E800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 8'd9},   // 2^30
    '{32'hCF000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 8'd2},   // -2^31
    '{32'h4F000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 8'd2},   // 2^31
    '{32'h4B000000, 1'b1, 32'h00800000, 1'b0, 1'b0, 8'd2},   // 2^23
    '{32'hCB800001, 1'b1, 32'hFEFFFFFE, 1'b0, 1'b0, 8'd3}    // -16777218.0
  };

  // Pulse the selected start line, then wait (bounded) for the result strobe.
  task automatic do_conv(input logic [31:0] d, input logic wide,
                         output logic [31:0] res, output logic ovf, output logic inv,
                         output int lat, output logic busy_start, output logic busy_done);
    @(negedge CLK);
    Data754 = d;
    if (wide) cs32 = 1'b1;
    else      inputCS = 1'b1;
    @(negedge CLK);
    inputCS = 1'b0;
    cs32    = 1'b0;
    busy_start = wide ? busy32 : busy16;
    lat = -1;
    for (int j = 1; j <= 40 && lat < 0; j++) begin
      @(negedge CLK);
      if ((wide ? ocs32 : ocs16) === 1'b1) lat = j;
    end
    res       = wide ? int32 : {16'h0000, int16};
    ovf       = wide ? ovf32 : ovf16;
    inv       = wide ? inv32 : inv16;
    busy_done = wide ? busy32 : busy16;
  endtask

  task automatic test_reset();
    RST = 1'b0; inputCS = 1'b0; cs32 = 1'b0; Data754 = 32'h0;
    #12;
    n_tests++;
    if ({int16, ocs16, busy16, ovf16, inv16} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset16: got %h required 0", {int16, ocs16, busy16, ovf16, inv16});
    end
    n_tests++;
    if ({int32, ocs32, busy32, ovf32, inv32} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset32: got %h required 0", {int32, ocs32, busy32, ovf32, inv32});
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_conversions();
    vec_t v;
    logic [31:0] res;
    logic ovf, inv, bs, bd;
    int lat;
    for (int i = 0; i < 21; i++) begin
      v = VECS[i];
      do_conv(v.d, v.wide, res, ovf, inv, lat, bs, bd);
      n_tests++;
      if (lat !== int'(v.lat)) begin
        n_fail++; $display("FAIL latency[%0d] %h: got %0d required %0d", i, v.d, lat, v.lat);
      end
      n_tests++;
      if (res !== v.r) begin
        n_fail++; $display("FAIL result[%0d] %h: got %h required %h", i, v.d, res, v.r);
      end
      n_tests++;
      if ({ovf, inv} !== {v.o, v.i}) begin
        n_fail++; $display("FAIL flags[%0d] %h: got ovf=%b inv=%b required ovf=%b inv=%b", i, v.d, ovf, inv, v.o, v.i);
      end
      n_tests++;
      if ({bs, bd} !== 2'b10) begin
        n_fail++; $display("FAIL busy[%0d] %h: got start=%b done=%b required 1/0", i, v.d, bs, bd);
      end
      @(negedge CLK);
      n_tests++;
      if ((v.wide ? ocs32 : ocs16) !== 1'b0) begin
        n_fail++; $display("FAIL strobe_width[%0d]: outputCS still high", i);
      end
      n_tests++;
      if ((v.wide ? int32 : {16'h0000, int16}) !== v.r) begin
        n_fail++; $display("FAIL hold[%0d]: got %h required %h", i, (v.wide ? int32 : {16'h0000, int16}), v.r);
      end
    end
  endtask

  task automatic test_ignored_start();
    int pulses = 0;
    logic [15:0] res = 16'hDEAD;
    @(negedge CLK);
    Data754 = 32'h3F800000; inputCS = 1'b1;
    @(negedge CLK);
    inputCS = 1'b0;
    repeat (3) @(negedge CLK);
    Data754 = 32'h40400000; inputCS = 1'b1;
    @(negedge CLK);
    inputCS = 1'b0;
    for (int j = 0; j < 50; j++) begin
      @(negedge CLK);
      if (ocs16 === 1'b1) begin
        pulses++;
        res = int16;
      end
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL ignored_start_pulses: got %0d required 1", pulses);
    end
    n_tests++;
    if (res !== 16'h0001) begin
      n_fail++; $display("FAIL ignored_start_result: got %h required 0001", res);
    end
  endtask

  task automatic test_back_to_back();
    logic seen = 1'b0;
    logic [15:0] first = 16'hDEAD;
    int lat = -1;
    @(negedge CLK);
    Data754 = 32'h3F000000; inputCS = 1'b1;
    @(negedge CLK);
    inputCS = 1'b0;
    for (int j = 0; j < 10 && !seen; j++) begin
      @(negedge CLK);
      if (ocs16 === 1'b1) begin
        seen = 1'b1;
        first = int16;
      end
    end
    n_tests++;
    if ({seen, first} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL b2b_first: got seen=%b res=%h required 1/0000", seen, first);
    end
    // start is sampled at the edge that ends the outputCS cycle
    Data754 = 32'h40400000; inputCS = 1'b1;
    @(negedge CLK);
    inputCS = 1'b0;
    for (int j = 1; j <= 40 && lat < 0; j++) begin
      @(negedge CLK);
      if (ocs16 === 1'b1) lat = j;
    end
    n_tests++;
    if (lat !== 24) begin
      n_fail++; $display("FAIL b2b_latency: got %0d required 24", lat);
    end
    n_tests++;
    if (int16 !== 16'h0003) begin
      n_fail++; $display("FAIL b2b_second: got %h required 0003", int16);
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    logic [31:0] res;
    logic ovf, inv, bs, bd;
    int lat;
    @(negedge CLK);
    Data754 = 32'h3F800000; inputCS = 1'b1;
    @(negedge CLK);
    inputCS = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    #1;
    n_tests++;
    if ({int16, ocs16, busy16, ovf16, inv16} !== 20'h0) begin
      n_fail++; $display("FAIL abort_clear: got %h required 0", {int16, ocs16, busy16, ovf16, inv16});
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      if (ocs16 === 1'b1 || busy16 === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL abort_no_strobe: got %0d active cycles required 0", pulses);
    end
    do_conv(32'h41200000, 1'b0, res, ovf, inv, lat, bs, bd);
    n_tests++;
    if ({res, lat} !== {32'h0000000A, 32'd22}) begin
      n_fail++; $display("FAIL abort_restart: got res=%h lat=%0d required 000a/22", res, lat);
    end
  endtask

  task automatic test_cs_held_across_reset();
    int active = 0;
    logic [31:0] res;
    logic ovf, inv, bs, bd;
    int lat;
    @(negedge CLK);
    RST = 1'b0; inputCS = 1'b1; Data754 = 32'h3F800000;
    @(negedge CLK);
    RST = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge CLK);
      if (busy16 === 1'b1 || ocs16 === 1'b1) active++;
    end
    n_tests++;
    if (active !== 0) begin
      n_fail++; $display("FAIL held_cs_no_start: got %0d active cycles required 0", active);
    end
    inputCS = 1'b0;
    do_conv(32'h40400000, 1'b0, res, ovf, inv, lat, bs, bd);
    n_tests++;
    if ({res, lat} !== {32'h00000003, 32'd24}) begin
      n_fail++; $display("FAIL held_cs_then_start: got res=%h lat=%0d required 0003/24", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    test_cs_held_across_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/float754_to_int.md
FLOAT754_TO_INT -- requirements
Module: float754_to_int

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 16, integer result width; legal range 2..32.
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Data754  input  32  IEEE-754 single-precision operand {sign, exp[7:0], frac[22:0]}.
REQ-005 SHALL have port inputCS  input  1  start request; a rising edge requests a conversion.
REQ-006 SHALL have port IntOutput  output  OUT_WIDTH  two's-complement result, registered.
REQ-007 SHALL have port outputCS  output  1  result-valid strobe, one cycle high.
REQ-008 SHALL have port Busy  output  1  high while a conversion is in progress (state != IDLE).
REQ-009 SHALL have port Overflow  output  1  result saturated (out of range or infinity).
REQ-010 SHALL have port Invalid  output  1  operand was NaN.

Function
REQ-011 SHALL register inputCS every cycle; start = inputCS & !prev_inputCS, sampled at a clock edge.
REQ-012 SHALL capture Data754 only when start is seen in IDLE; start while Busy SHALL be ignored and not queued.
REQ-013 SHALL implement FSM IDLE -> DECODE -> SHIFT -> FINISH -> IDLE; FINISH always returns to IDLE.
REQ-014 DECODE SHALL compute e = exp - 127, mantissa M = {1, frac} held in a 32-bit work register, and shift count N = |23 - e| for in-range operands, else N = 0.
REQ-015 DECODE classification: exp==0 (zero/denormal) or e<0 -> result 0; exp==255 with frac!=0 -> result 0, Invalid=1; exp==255 with frac==0 -> saturate; e >= OUT_WIDTH-1 -> saturate, except sign=1, e==OUT_WIDTH-1, frac==0 -> result -2^(OUT_WIDTH-1), Overflow=0.
REQ-016 Saturation SHALL give 2^(OUT_WIDTH-1)-1 for sign=0 and -2^(OUT_WIDTH-1) for sign=1, with Overflow=1.
REQ-017 SHIFT SHALL move M one bit per cycle, right if e<23, left if e>23, for exactly N cycles; N=0 skips SHIFT (DECODE -> FINISH).
REQ-018 Right shifts SHALL discard bits (truncation toward zero); no rounding.
REQ-019 FINISH SHALL load IntOutput with the magnitude's low OUT_WIDTH bits, negated in two's complement if sign=1 (0 stays 0, including -0.0), update Overflow/Invalid, and set outputCS=1.
REQ-020 Timing: capture at edge k; DECODE at k+1; SHIFT at k+2..k+N+1; outputs and outputCS=1 visible after edge k+N+2; outputCS=0 after edge k+N+3. Maximum N=23, so worst-case latency is 25 cycles.
REQ-021 A start seen at edge k+N+3 (the cycle outputCS is high, state IDLE) SHALL be accepted: back-to-back conversions.
REQ-022 IntOutput, Overflow and Invalid SHALL hold their values until the next FINISH.
REQ-023 Busy SHALL be high after edge k through edge k+N+2 and low from then on.

Reset
REQ-024 RST low SHALL immediately force IntOutput=0, outputCS=0, Busy=0, Overflow=0, Invalid=0, prev_inputCS=0, state=IDLE, and clear work registers.
REQ-025 RST asserted mid-conversion SHALL abort it with no outputCS pulse; after release, the first inputCS rising edge starts a fresh conversion.
REQ-026 inputCS held high across reset release SHALL NOT start a conversion; it needs a low-then-high transition.

Verification
REQ-027 0x3F800000 (1.0), OUT_WIDTH=16 -> IntOutput=0x0001, flags 0, outputCS 25 cycles after capture edge.
REQ-028 0xC0200000 (-2.5) -> 0xFFFE (-2), N=22; 0x3F000000 (0.5) -> 0x0000 via N=0 path, outputCS 2 cycles after capture.
REQ-029 OUT_WIDTH=16: 0x47000000 (32768.0) -> 0x7FFF, Overflow=1; 0xC7000000 (-32768.0) -> 0x8000, Overflow=0; 0xFF800000 (-inf) -> 0x8000, Overflow=1.
REQ-030 0x7FC00000 (NaN) -> 0x0000, Invalid=1; next 0x40400000 (3.0) -> 0x0003, Invalid=0.
REQ-031 Second inputCS pulse while Busy -> ignored, exactly one outputCS; pulse in the outputCS cycle -> accepted, second result follows.
REQ-032 RST low during SHIFT of 0x3F800000 -> all outputs 0 at once, no outputCS; next start with 0x41200000 (10.0) -> 0x000A.
